// File: rtl/aes_add_round_key.sv
// rtl/aes_add_round_key.sv - AES-128 AddRoundKey stage with on-the-fly round-key expansion

// Combinational AES byte S-box: GF(2^8) inverse followed by the affine map.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = x;
    bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Inverse computed as a^254 = a^2 * a^4 * ... * a^128; zero maps to zero.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] pw;
    logic [7:0] r;
    pw = gf_mul(a, a);
    r  = pw;
    for (int i = 0; i < 6; i++) begin
      pw = gf_mul(pw, pw);
      r  = gf_mul(r, pw);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign s_o = sbox_f(a_i);

endmodule

module aes_add_round_key (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic [3:0]   out_round,
  output logic [3:0]   round
);

  logic [127:0] key_q, key_d;
  logic [127:0] master_q, master_d;
  logic [3:0]   round_q, round_d;
  logic         key_ok_q, key_ok_d;
  logic [127:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic [3:0]   out_round_q, out_round_d;

  logic         xfer;
  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  // A key load always wins the cycle so the new schedule starts cleanly.
  assign in_ready = key_ok_q && !key_load && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  // Round constant for the step that produces round key round_q+1.
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0    = key_q[127:96];
  assign w1    = key_q[95:64];
  assign w2    = key_q[63:32];
  assign w3    = key_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.a_i(rot_w[31:24]), .s_o(sub_w[31:24]));
  aes_sbox u_sbox1 (.a_i(rot_w[23:16]), .s_o(sub_w[23:16]));
  aes_sbox u_sbox2 (.a_i(rot_w[15:8]),  .s_o(sub_w[15:8]));
  aes_sbox u_sbox3 (.a_i(rot_w[7:0]),   .s_o(sub_w[7:0]));

  assign temp     = sub_w ^ {rcon, 24'h000000};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Key schedule: load restarts at round 0, each transfer advances one step, round 10 wraps.
  always_comb begin
    key_d    = key_q;
    master_d = master_q;
    round_d  = round_q;
    key_ok_d = key_ok_q;
    if (key_load) begin
      key_d    = key_in;
      master_d = key_in;
      round_d  = 4'd0;
      key_ok_d = 1'b1;
    end else if (xfer) begin
      if (round_q == 4'd10) begin
        key_d   = master_q;
        round_d = 4'd0;
      end else begin
        key_d   = next_key;
        round_d = round_q + 4'd1;
      end
    end
  end

  // Output register: fill on transfer, otherwise drop valid once drained.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_round_d = out_round_q;
    if (xfer) begin
      out_d       = in ^ key_q;
      out_round_d = round_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      master_q    <= '0;
      round_q     <= '0;
      key_ok_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_round_q <= '0;
    end else begin
      key_q       <= key_d;
      master_q    <= master_d;
      round_q     <= round_d;
      key_ok_q    <= key_ok_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_round_q <= out_round_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_round = out_round_q;
  assign round     = round_q;

endmodule

// File: tb/tb_aes_add_round_key.sv
// tb/tb_aes_add_round_key.sv - self-checking bench for aes_add_round_key

module tb_aes_add_round_key;

  logic         clk;
  logic         rst_n;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;
  logic [3:0]   out_round;
  logic [3:0]   round;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbt [256];

  logic [127:0] m_key;
  logic         m_key_ok;
  int           m_round;
  logic         m_ov;
  logic [127:0] m_out;
  int           m_oround;

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] E0   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] P1   = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] E1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic         kl;
    logic [127:0] key;
    logic         iv;
    logic [127:0] d;
    logic         ordy;
    logic         exp_ov;
    logic         chk_out;
    logic [127:0] exp_out;
    logic [3:0]   exp_oround;
    logic [3:0]   exp_round;
  } vec_t;

  vec_t tbl [13];

  aes_add_round_key dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .out_round (out_round),
    .round     (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  // Full AES-128 key schedule from the cipher key; returns round key r.
  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbt[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbt[0] = 8'h63;
  endtask

  task automatic model_reset();
    m_key    = '0;
    m_key_ok = 1'b0;
    m_round  = 0;
    m_ov     = 1'b0;
    m_out    = '0;
    m_oround = 0;
  endtask

  // One cycle: drive at negedge, check ready, advance the model, check registered outputs.
  task automatic step(input logic kl, input logic [127:0] k, input logic iv,
                      input logic [127:0] d, input logic ordy);
    logic rdy;
    key_load  = kl;
    key_in    = k;
    in_valid  = iv;
    din       = d;
    out_ready = ordy;
    #1;
    rdy = m_key_ok && !kl && (!m_ov || ordy);
    check("in_ready", 128'(in_ready), 128'(rdy));
    if (iv && rdy) begin
      m_out    = d ^ round_key(m_key, m_round);
      m_oround = m_round;
      m_ov     = 1'b1;
      m_round  = (m_round + 1) % 11;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (kl) begin
      m_key    = k;
      m_key_ok = 1'b1;
      m_round  = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", 128'(out_valid), 128'(m_ov));
    check("out", dout, m_out);
    check("out_round", 128'(out_round), 128'(m_oround));
    check("round", 128'(round), 128'(m_round));
  endtask

  initial begin
    rst_n     = 1'b0;
    key_load  = 1'b0;
    key_in    = '0;
    in_valid  = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    build_sbox();
    model_reset();

    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out", dout, 128'(0));
    check("rst_out_round", 128'(out_round), 128'(0));
    check("rst_round", 128'(round), 128'(0));
    rst_n = 1'b1;

    // No key loaded yet: nothing may be accepted.
    for (int i = 0; i < 10; i++)
      step(1'b0, '0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    check("nokey_out_valid", 128'(out_valid), 128'(0));

    // Known-answer block: load, rounds 0..10, wrap to round 0.
    tbl[0] = '{1'b1, K1, 1'b1, P0, 1'b1, 1'b0, 1'b0, '0, 4'd0, 4'd0};
    tbl[1] = '{1'b0, '0, 1'b1, P0, 1'b1, 1'b1, 1'b1, E0, 4'd0, 4'd1};
    tbl[2] = '{1'b0, '0, 1'b1, P1, 1'b1, 1'b1, 1'b1, E1, 4'd1, 4'd2};
    for (int r = 2; r <= 10; r++)
      tbl[r+1] = '{1'b0, '0, 1'b1, '0, 1'b1, 1'b1, 1'b1,
                   (r == 10) ? RK10 : round_key(K1, r), 4'(r), 4'((r + 1) % 11)};
    tbl[12] = '{1'b0, '0, 1'b1, '0, 1'b1, 1'b1, 1'b1, K1, 4'd0, 4'd1};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].kl, tbl[i].key, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      check("tbl_out_valid", 128'(out_valid), 128'(tbl[i].exp_ov));
      if (tbl[i].chk_out) begin
        check("tbl_out", dout, tbl[i].exp_out);
        check("tbl_out_round", 128'(out_round), 128'(tbl[i].exp_oround));
      end
      check("tbl_round", 128'(round), 128'(tbl[i].exp_round));
    end

    // Advance to a round-3 result, then hold under backpressure.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1, 128'h5a5a, 1'b0);
      check("hold_out", dout, round_key(K1, 3));
      check("hold_out_round", 128'(out_round), 128'(3));
      check("hold_round", 128'(round), 128'(4));
      check("hold_in_ready", 128'(in_ready), 128'(0));
    end
    step(1'b0, '0, 1'b1, '0, 1'b1);
    check("fill_out", dout, round_key(K1, 4));
    check("fill_out_valid", 128'(out_valid), 128'(1));
    check("fill_out_round", 128'(out_round), 128'(4));
    step(1'b0, '0, 1'b1, '0, 1'b1);

    // Key load at round 6 aborts the block.
    check("pre_load_round", 128'(round), 128'(6));
    step(1'b1, K2, 1'b1, 128'h1234, 1'b1);
    check("load_round", 128'(round), 128'(0));
    check("load_out_held", dout, round_key(K1, 5));
    step(1'b0, '0, 1'b1, '0, 1'b1);
    check("newkey_out", dout, K2);
    check("newkey_out_round", 128'(out_round), 128'(0));

    // Asynchronous reset mid-block with a result pending.
    check("pre_rst_out_valid", 128'(out_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_out", dout, 128'(0));
    check("arst_out_round", 128'(out_round), 128'(0));
    check("arst_round", 128'(round), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 128'hffff, 1'b1);
    check("post_rst_no_xfer", 128'(out_valid), 128'(0));

    // Randomized traffic with occasional key reloads.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 39) == 0), {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
